// File: rtl/jtag_tap_fabric_if.sv
// Channel-side bundle between the fabric TAP and the user DR channels
// (DTMCS, DMI, ...). The TAP drives the strobes; channels return serial data.
interface jtag_tap_fabric_if #(
    parameter int NumChannels = 2
);
    logic                   tck_o;
    logic                   tdi_o;
    logic                   dmi_clear_o;
    logic                   capture_o;
    logic                   shift_o;
    logic                   update_o;
    logic [NumChannels-1:0] chan_select_o;
    logic [NumChannels-1:0] chan_tdo_i;

    modport master (
        output tck_o,
        output tdi_o,
        output dmi_clear_o,
        output capture_o,
        output shift_o,
        output update_o,
        output chan_select_o,
        input  chan_tdo_i
    );

    modport slave (
        input  tck_o,
        input  tdi_o,
        input  dmi_clear_o,
        input  capture_o,
        input  shift_o,
        input  update_o,
        input  chan_select_o,
        output chan_tdo_i
    );
endinterface

// File: rtl/jtag_tap_fabric.sv
// Fabric IEEE 1149.1 TAP: state machine, IR, IDCODE/BYPASS DRs and
// one-hot selection of user DR channels, with falling-edge TDO.
module jtag_tap_fabric #(
    parameter int          IrLength    = 5,
    parameter logic [31:0] IdcodeValue = 32'h00000001,
    parameter int          NumChannels = 2,
    parameter int          ChanIrBase  = 'h10
) (
    input  logic                tck_i,
    input  logic                trst_i,
    input  logic                tms_i,
    input  logic                td_i,
    output logic                td_o,
    output logic                tdo_oe_o,
    output logic [IrLength-1:0] ir_o,
    output logic [3:0]          tap_state_o,
    jtag_tap_fabric_if.master   chan
);

    typedef enum logic [3:0] {
        TLR     = 4'd0,
        RTI     = 4'd1,
        SEL_DR  = 4'd2,
        CAP_DR  = 4'd3,
        SH_DR   = 4'd4,
        EX1_DR  = 4'd5,
        PAU_DR  = 4'd6,
        EX2_DR  = 4'd7,
        UPD_DR  = 4'd8,
        SEL_IR  = 4'd9,
        CAP_IR  = 4'd10,
        SH_IR   = 4'd11,
        EX1_IR  = 4'd12,
        PAU_IR  = 4'd13,
        EX2_IR  = 4'd14,
        UPD_IR  = 4'd15
    } state_e;

    localparam logic [IrLength-1:0] IrIdcode = IrLength'(1);

    state_e                  state_q, state_d;
    logic [IrLength-1:0]     ir_sr_q, ir_sr_d;
    logic [IrLength-1:0]     ir_q, ir_d;
    logic [31:0]             idcode_sr_q, idcode_sr_d;
    logic                    bypass_q, bypass_d;
    logic                    td_q, td_d;
    logic                    oe_q, oe_d;

    logic [NumChannels-1:0]  chan_sel;
    logic                    sel_idcode;
    logic                    sel_chan;
    logic                    shifting;
    logic                    tdo_src;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:     state_d = tms_i ? TLR    : RTI;
            RTI:     state_d = tms_i ? SEL_DR : RTI;
            SEL_DR:  state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms_i ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = tms_i ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms_i ? SEL_DR : RTI;
            SEL_IR:  state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms_i ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = tms_i ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms_i ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // The IR latch lags entry into TLR by one edge; mask it so the
    // instruction reads as IDCODE for the whole time we sit in TLR.
    assign ir_o = (state_q == TLR) ? IrIdcode : ir_q;

    always_comb begin
        chan_sel = '0;
        for (int k = 0; k < NumChannels; k++) begin
            chan_sel[k] = (ir_o == IrLength'(ChanIrBase + k));
        end
    end

    assign sel_idcode = (ir_o == IrIdcode);
    assign sel_chan   = |chan_sel;
    assign shifting   = (state_q == SH_DR) || (state_q == SH_IR);

    always_comb begin
        ir_sr_d     = ir_sr_q;
        ir_d        = ir_q;
        idcode_sr_d = idcode_sr_q;
        bypass_d    = bypass_q;
        if (state_q == CAP_IR) begin
            ir_sr_d = IrIdcode;
        end else if (state_q == SH_IR) begin
            ir_sr_d = {td_i, ir_sr_q[IrLength-1:1]};
        end
        if (state_q == TLR) begin
            ir_d = IrIdcode;
        end else if (state_q == UPD_IR) begin
            ir_d = ir_sr_q;
        end
        if (sel_idcode) begin
            if (state_q == CAP_DR) begin
                idcode_sr_d = IdcodeValue;
            end else if (state_q == SH_DR) begin
                idcode_sr_d = {td_i, idcode_sr_q[31:1]};
            end
        end
        if (!sel_idcode && !sel_chan) begin
            if (state_q == CAP_DR) begin
                bypass_d = 1'b0;
            end else if (state_q == SH_DR) begin
                bypass_d = td_i;
            end
        end
    end

    always_comb begin
        tdo_src = bypass_q;
        if (state_q == SH_IR) begin
            tdo_src = ir_sr_q[0];
        end else if (sel_idcode) begin
            tdo_src = idcode_sr_q[0];
        end else if (sel_chan) begin
            tdo_src = |(chan_sel & chan.chan_tdo_i);
        end
        td_d = shifting & tdo_src;
        oe_d = shifting;
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state_q     <= TLR;
            ir_sr_q     <= '0;
            ir_q        <= IrIdcode;
            idcode_sr_q <= '0;
            bypass_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_sr_q     <= ir_sr_d;
            ir_q        <= ir_d;
            idcode_sr_q <= idcode_sr_d;
            bypass_q    <= bypass_d;
        end
    end

    // TDO changes on the falling edge so the probe samples it mid-cycle.
    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            td_q <= 1'b0;
            oe_q <= 1'b0;
        end else begin
            td_q <= td_d;
            oe_q <= oe_d;
        end
    end

    assign td_o        = td_q;
    assign tdo_oe_o    = oe_q;
    assign tap_state_o = state_q;

    assign chan.tck_o         = tck_i;
    assign chan.tdi_o         = td_i;
    assign chan.dmi_clear_o   = (state_q == TLR);
    assign chan.capture_o     = (state_q == CAP_DR);
    assign chan.shift_o       = (state_q == SH_DR);
    assign chan.update_o      = (state_q == UPD_DR);
    assign chan.chan_select_o = chan_sel;

endmodule

// File: tb/tb_jtag_tap_fabric.sv
// Randomised scans of the fabric TAP checked against a scan-level
// reference model of the TAP walk, IR and selected data register.
module tb_jtag_tap_fabric;

    localparam int          IRL = 5;
    localparam logic [31:0] IDC = 32'h4BA00477;
    localparam int          NCH = 2;
    localparam int          CHB = 'h10;

    logic tck;
    logic trst;
    logic tms;
    logic tdi;
    logic td_o;
    logic oe;
    logic [IRL-1:0] ir_o;
    logic [3:0] st_o;

    jtag_tap_fabric_if #(.NumChannels(NCH)) cif ();

    jtag_tap_fabric #(
        .IrLength(IRL),
        .IdcodeValue(IDC),
        .NumChannels(NCH),
        .ChanIrBase(CHB)
    ) dut (
        .tck_i(tck),
        .trst_i(trst),
        .tms_i(tms),
        .td_i(tdi),
        .td_o(td_o),
        .tdo_oe_o(oe),
        .ir_o(ir_o),
        .tap_state_o(st_o),
        .chan(cif.master)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    int checks = 0;
    int errors = 0;

    // Standard 1149.1 walk: nxt[state][tms]
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int             m_state;
    logic [IRL-1:0] m_ir;
    logic [IRL-1:0] m_shadow;
    bit             m_pend;

    function automatic logic [NCH-1:0] exp_sel(input logic [IRL-1:0] ir);
        logic [NCH-1:0] s;
        s = '0;
        for (int k = 0; k < NCH; k++) s[k] = (int'(ir) == CHB + k);
        return s;
    endfunction

    function automatic logic [NCH-1:0] chan_drive(input logic b);
        logic [NCH-1:0] v;
        for (int k = 0; k < NCH; k++) v[k] = b ^ k[0];
        return v;
    endfunction

    function automatic logic ref_bit(input bit is_ir, input logic [IRL-1:0] ir,
                                     input int i, input logic [63:0] din,
                                     input logic [63:0] cpat);
        if (is_ir) return (i < IRL) ? (i == 0) : din[i-IRL];
        if (ir == IRL'(1)) return (i < 32) ? IDC[i] : din[i-32];
        for (int k = 0; k < NCH; k++)
            if (int'(ir) == CHB + k) return cpat[i] ^ k[0];
        return (i == 0) ? 1'b0 : din[i-1];
    endfunction

    task automatic tick(input logic t, input logic d, output logic q);
        bit sh;
        tms = t;
        tdi = d;
        @(posedge tck);
        if (m_state == 15 && m_pend) begin
            m_ir = m_shadow;
            m_pend = 0;
        end
        m_state = t ? nxt1[m_state] : nxt0[m_state];
        if (m_state == 0) m_ir = IRL'(1);
        #1;
        checks++;
        if (st_o !== 4'(m_state) || ir_o !== m_ir || cif.chan_select_o !== exp_sel(m_ir)) begin
            errors++;
            $display("FAIL state/ir: state %0d exp %0d ir %h exp %h sel %b exp %b",
                     st_o, m_state, ir_o, m_ir, cif.chan_select_o, exp_sel(m_ir));
        end
        checks++;
        if (cif.capture_o !== (m_state == 3) || cif.shift_o !== (m_state == 4) ||
            cif.update_o !== (m_state == 8) || cif.dmi_clear_o !== (m_state == 0) ||
            cif.tdi_o !== d) begin
            errors++;
            $display("FAIL strobes: cap %b shf %b upd %b clr %b tdi %b in state %0d",
                     cif.capture_o, cif.shift_o, cif.update_o, cif.dmi_clear_o,
                     cif.tdi_o, m_state);
        end
        @(negedge tck);
        #1;
        sh = (m_state == 4) || (m_state == 11);
        checks++;
        if (oe !== sh || (!sh && td_o !== 1'b0)) begin
            errors++;
            $display("FAIL tdo_oe: oe %b td %b exp oe %b in state %0d", oe, td_o, sh, m_state);
        end
        q = td_o;
    endtask

    task automatic scan(input bit is_ir, input int n, input logic [63:0] din,
                        input logic [63:0] cpat, output logic [63:0] dout);
        logic b;
        dout = '0;
        cif.chan_tdo_i = chan_drive(cpat[0]);
        tick(1, 0, b);
        if (is_ir) tick(1, 0, b);
        tick(0, 0, b);
        tick(0, 0, b);
        for (int i = 0; i < n; i++) begin
            dout[i] = b;
            cif.chan_tdo_i = chan_drive(cpat[i+1]);
            tick(i == n - 1, din[i], b);
        end
        if (is_ir) begin
            for (int j = 0; j < IRL; j++) m_shadow[j] = din[n-IRL+j];
            m_pend = 1;
        end
        tick(1, 0, b);
        tick(0, 0, b);
    endtask

    task automatic test_reset;
        logic b;
        trst = 1'b1;
        repeat (2) @(posedge tck);
        #1;
        checks++;
        if (st_o !== 4'd0 || ir_o !== IRL'(1) || td_o !== 1'b0 || oe !== 1'b0 ||
            cif.dmi_clear_o !== 1'b1 || cif.capture_o !== 1'b0 ||
            cif.shift_o !== 1'b0 || cif.update_o !== 1'b0 || cif.chan_select_o !== '0) begin
            errors++;
            $display("FAIL reset: state %0d ir %h td %b oe %b clr %b sel %b",
                     st_o, ir_o, td_o, oe, cif.dmi_clear_o, cif.chan_select_o);
        end
        @(negedge tck);
        #1 trst = 1'b0;
        tick(1, 0, b);
        tick(0, 0, b);
    endtask

    task automatic test_idcode;
        logic [63:0] din, dout;
        din = {$urandom, $urandom};
        scan(0, 40, din, '0, dout);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (dout[i] !== ref_bit(0, m_ir, i, din, '0)) begin
                errors++;
                $display("FAIL idcode bit %0d: got %b exp %b", i, dout[i], ref_bit(0, m_ir, i, din, '0));
            end
        end
    endtask

    task automatic test_ir_load(input logic [IRL-1:0] code);
        logic [63:0] din, dout;
        din = {59'($urandom), code};
        scan(1, IRL, din, '0, dout);
        for (int i = 0; i < IRL; i++) begin
            checks++;
            if (dout[i] !== ref_bit(1, m_ir, i, din, '0)) begin
                errors++;
                $display("FAIL ir_capture bit %0d: got %b", i, dout[i]);
            end
        end
        checks++;
        if (ir_o !== code || cif.chan_select_o !== exp_sel(code)) begin
            errors++;
            $display("FAIL ir_load: ir %h exp %h sel %b", ir_o, code, cif.chan_select_o);
        end
    endtask

    task automatic test_tms_reset;
        logic b;
        test_ir_load(IRL'(5'h11));
        tick(1, 0, b);
        tick(0, 0, b);
        tick(0, 0, b);
        repeat (5) tick(1, 0, b);
        checks++;
        if (st_o !== 4'd0 || ir_o !== IRL'(1) || cif.dmi_clear_o !== 1'b1) begin
            errors++;
            $display("FAIL tms_reset: state %0d ir %h clr %b", st_o, ir_o, cif.dmi_clear_o);
        end
        tick(0, 0, b);
    endtask

    task automatic test_dr(input logic [IRL-1:0] code, input int n,
                           input logic [63:0] din, input logic [63:0] cpat);
        logic [63:0] dout;
        test_ir_load(code);
        scan(0, n, din, cpat, dout);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (dout[i] !== ref_bit(0, m_ir, i, din, cpat)) begin
                errors++;
                $display("FAIL dr ir=%h bit %0d: got %b exp %b", code, i, dout[i],
                         ref_bit(0, m_ir, i, din, cpat));
            end
        end
    endtask

    task automatic test_channel;
        test_dr(IRL'(5'h10), 4, 64'h0, 64'b1101);
        test_dr(IRL'(5'h11), 6, 64'($urandom), 64'($urandom));
    endtask

    task automatic test_bypass;
        test_dr(IRL'(5'h1F), 8, 64'b10110010, 64'($urandom));
        test_dr(IRL'(5'h05), 8, 64'b10110010, 64'($urandom));
    endtask

    task automatic test_random;
        logic [IRL-1:0] code;
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 3))
                0: code = IRL'(1);
                1: code = IRL'(CHB);
                2: code = IRL'(CHB + 1);
                default: code = IRL'($urandom);
            endcase
            test_dr(code, $urandom_range(1, 40), {$urandom, $urandom}, {$urandom, $urandom});
        end
    endtask

    task automatic test_async_mid;
        logic b;
        test_ir_load(IRL'(5'h11));
        tick(1, 0, b);
        tick(1, 0, b);
        tick(0, 0, b);
        tick(0, 0, b);
        repeat (3) tick(0, 1'($urandom), b);
        #2 trst = 1'b1;
        #1;
        checks++;
        if (st_o !== 4'd0 || ir_o !== IRL'(1) || oe !== 1'b0 || td_o !== 1'b0 ||
            cif.dmi_clear_o !== 1'b1) begin
            errors++;
            $display("FAIL async_mid: state %0d ir %h oe %b td %b", st_o, ir_o, oe, td_o);
        end
        m_state = 0;
        m_ir = IRL'(1);
        m_pend = 0;
        @(negedge tck);
        #1 trst = 1'b0;
        tick(0, 0, b);
        test_idcode();
    endtask

    initial begin
        trst = 1'b1;
        tms = 1'b1;
        tdi = 1'b0;
        cif.chan_tdo_i = '0;
        m_state = 0;
        m_ir = IRL'(1);
        m_shadow = '0;
        m_pend = 0;
        test_reset();
        test_idcode();
        test_tms_reset();
        test_channel();
        test_bypass();
        test_random();
        test_async_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_tap_fabric.md
# jtag_tap_fabric

Fabric-implemented IEEE 1149.1 TAP controller with a parametrised instruction register, IDCODE and BYPASS registers, and `NumChannels` user data-register channels. It replaces the vendor boundary-scan primitive path, so the debug transport also works on parts or toolchains without that primitive. It sits between the board JTAG pins and the debug-transport DR logic. DTMCS is channel 0 and DMI is channel 1 by default.

## Interface
- `IrLength`, 5: instruction register width; minimum 2.
- `IdcodeValue`, 32'h00000001: value loaded into the IDCODE DR; bit 0 must be 1.
- `NumChannels`, 2: number of user DR channels; range 1..(2^IrLength − 3).
- `ChanIrBase`, 'h10: IR code of channel 0; channel k is selected by IR code `ChanIrBase+k`.

Ports:
- `tck_i`  in  1  JTAG clock; the only clock.
- `trst_i`  in  1  asynchronous, active-high reset.
- `tms_i`  in  1  test mode select, sampled on rising `tck_i`.
- `td_i`  in  1  test data in, sampled on rising `tck_i`.
- `td_o`  out  1  test data out, updated on falling `tck_i`.
- `tdo_oe_o`  out  1  output enable for `td_o`, updated on falling `tck_i`.
- `tck_o`  out  1  `tck_i` passed through to the channel logic.
- `dmi_clear_o`  out  1  high while the controller is in Test-Logic-Reset.
- `capture_o`  out  1  high in Capture-DR.
- `shift_o`  out  1  high in Shift-DR.
- `update_o`  out  1  high in Update-DR.
- `tdi_o`  out  1  `td_i` passed through to the channel logic.
- `chan_select_o`  out  NumChannels  one-hot channel select, decoded from the IR.
- `chan_tdo_i`  in  NumChannels  serial output of each channel DR.
- `ir_o`  out  IrLength  current instruction.
- `tap_state_o`  out  4  current TAP state, for debug.

## Operation
- **TAP state machine.** 16 states with the standard 1149.1 TMS transitions.
  - Encoding: TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauseDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, PauseIR=13, Ex2IR=14, UpdIR=15.
  - TMS held high for 5 rising edges reaches TLR from any state.
- **IR.**
  - Reserved codes: IDCODE = 1; BYPASS = all ones.
  - In CapIR the IR shift register loads `{0…,01}`.
  - In ShIR it shifts right: `td_i` enters the MSB, and the LSB drives `td_o`.
  - In UpdIR it is copied to `ir_o`.
  - In TLR, `ir_o` is forced to IDCODE.
- **DR selection by `ir_o`.**
  - IDCODE: 32-bit register; loads `IdcodeValue` in CapDR and shifts right in ShDR.
  - `ChanIrBase+k` (k < NumChannels): `chan_select_o[k]`=1 and `td_o` source is `chan_tdo_i[k]`.
  - Any other code: 1-bit BYPASS register; loads 0 in CapDR and loads `td_i` in ShDR.
- **Channel strobes.**
  - `capture_o`, `shift_o` and `update_o` are combinational decodes of the state, independent of the IR.
  - Channel logic qualifies them with its own `chan_select_o` bit.
  - `chan_select_o` is combinational from `ir_o`, so it is stable from UpdIR onward.
- **Output path.**
  - On each falling edge, `td_o` takes the selected serial source if the state is ShIR or ShDR.
  - On each falling edge, `tdo_oe_o` = (state is ShIR or ShDR).
  - Outside those states, `td_o` is driven 0.
- **Async reset** (`trst_i`=1, regardless of clock):
  - state = TLR, `ir_o` = IDCODE, IR and DR shift registers = 0.
  - `td_o`=0, `tdo_oe_o`=0, `dmi_clear_o`=1, `capture_o`/`shift_o`/`update_o`=0.
  - `chan_select_o`=0, `tap_state_o`=0.
  - Deassertion is synchronised by the first rising `tck_i`.

## Timing
- **State.** The state register updates on rising `tck_i`. All strobes and `tap_state_o` follow the state combinationally in the same cycle.
- **Shift vs `td_o`.** Shift registers advance on the rising edge that leaves ShDR/ShIR, and also on rising edges that stay in them. `td_o` presents bit 0 on the falling edge after entering ShDR/ShIR.
- **IDCODE readout.** The first TDO bit is `IdcodeValue[0]`, valid half a cycle after the CapDR→ShDR transition.
- **BYPASS latency.** TDI reaches TDO after exactly one shift cycle.
- **IR change.** `ir_o` changes on the rising edge that leaves UpdIR. It is unaffected by Pause/Exit states.
- **Reset mid-shift.** A reset during ShDR or ShIR aborts immediately. Partial shift data is discarded and there is no UpdIR/UpdDR effect.

## Test plan
- **Reset and IDCODE.** Assert `trst_i`, release, then TMS 0,1,0,0 (RTI→SelDR→CapDR→ShDR) and shift 32 bits → TDO stream LSB-first = 0x00000001; `dmi_clear_o` is 1 until leaving TLR.
- **TMS reset.** From ShDR, hold TMS=1 for 5 edges → `tap_state_o`=0, `ir_o`=5'h01, `dmi_clear_o`=1.
- **IR capture and load.** Go to ShIR and shift in 5'h11 → first 5 TDO bits are 1,0,0,0,0. After UpdIR: `ir_o`=5'h11 and `chan_select_o`=2'b10.
- **Channel path.** With IR=5'h10, drive `chan_tdo_i[0]` with pattern 1,0,1,1. Expect:
  - TDO follows the pattern on falling edges;
  - `capture_o`, `shift_o` and `update_o` each pulse in CapDR, ShDR and UpdDR respectively;
  - `tdi_o` equals `td_i`.
- **BYPASS.** Load IR=5'h1F (and separately the undefined code 5'h05), shift 8'b10110010 → TDO is 0 followed by the input delayed by one cycle; `chan_select_o`=0.
- **Async reset mid-shift.** Pulse `trst_i` mid-ShIR after 3 bits → state TLR and `ir_o`=IDCODE immediately; `tdo_oe_o`=0 without a clock edge.
